// File: rtl/pipeline_mem_arbiter_if.sv
// pipeline_mem_arbiter_if: pipeline request, memory port and hazard signals of the memory arbiter.
interface pipeline_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_rdata;
  logic              fetch_valid;
  logic              data_req;
  logic              data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_valid;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              stall_fetch;
  logic              stall_data;
  logic              flush_e;
  logic              bus_error;
  modport master (
    input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata, mem_rdata, mem_ack,
    output fetch_rdata, fetch_valid, data_rdata, data_valid, mem_req, mem_we, mem_addr, mem_wdata,
           stall_fetch, stall_data, flush_e, bus_error
  );
  modport slave (
    output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata, mem_rdata, mem_ack,
    input  fetch_rdata, fetch_valid, data_rdata, data_valid, mem_req, mem_we, mem_addr, mem_wdata,
           stall_fetch, stall_data, flush_e, bus_error
  );
endinterface

// File: rtl/pipeline_mem_arbiter.sv
// pipeline_mem_arbiter: shares one memory port between IF and MEM; data wins, fetches are never pre-empted.
// Define ARB_TIMEOUT_EN to abort accesses after TIMEOUT busy cycles with a sticky bus_error.
module pipeline_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic clock,
  input logic reset,
  pipeline_mem_arbiter_if.master bus
);
  typedef enum logic [2:0] {IDLE, D_BUSY, F_BUSY, D_RESP, F_RESP} state_t;
  state_t state, state_nx;
  logic busy, done, abort;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, fetch_rdata, data_rdata;
  assign busy = state == D_BUSY || state == F_BUSY;
  assign done = bus.mem_ack | abort;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = bus.data_req ? D_BUSY : bus.fetch_req ? F_BUSY : IDLE;
      D_BUSY:  state_nx = done ? D_RESP : D_BUSY;
      F_BUSY:  state_nx = done ? F_RESP : F_BUSY;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      fetch_rdata <= '0;
      data_rdata  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.data_req) begin
        mem_we    <= bus.data_we;
        mem_addr  <= bus.data_addr;
        mem_wdata <= bus.data_wdata;
      end else if (state == IDLE && bus.fetch_req) begin
        mem_we   <= 1'b0;
        mem_addr <= bus.fetch_addr;
      end
      // a timed-out access returns zero data; stores keep the last load data on a real ack
      if (state == D_BUSY && bus.mem_ack && !mem_we) data_rdata <= bus.mem_rdata;
      else if (state == D_BUSY && abort) data_rdata <= '0;
      if (state == F_BUSY && bus.mem_ack) fetch_rdata <= bus.mem_rdata;
      else if (state == F_BUSY && abort) fetch_rdata <= '0;
    end
  end
`ifdef ARB_TIMEOUT_EN
  logic [$clog2(TIMEOUT+1)-1:0] cnt;
  logic err;
  assign abort = busy && !bus.mem_ack && 32'(cnt) == TIMEOUT - 1;
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= (busy && !bus.mem_ack) ? cnt + 1'b1 : '0;
      err <= err | abort;
    end
  end
  assign bus.bus_error = err;
`else
  assign abort = 1'b0;
  assign bus.bus_error = 1'b0;
`endif
  assign bus.mem_req     = busy;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;
  assign bus.fetch_rdata = fetch_rdata;
  assign bus.data_rdata  = data_rdata;
  assign bus.fetch_valid = state == F_RESP;
  assign bus.data_valid  = state == D_RESP;
  assign bus.stall_data  = bus.data_req & ~bus.data_valid;
  assign bus.stall_fetch = bus.stall_data | (bus.fetch_req & ~bus.fetch_valid);
  assign bus.flush_e     = bus.stall_fetch & ~bus.stall_data;
endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// tb_pipeline_mem_arbiter: directed vectors with hand-computed expectations for the memory arbiter.
module tb_pipeline_mem_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  pipeline_mem_arbiter_if bus ();
  pipeline_mem_arbiter #(.TIMEOUT(4)) dut (.clock(clock), .reset(reset), .bus(bus.master));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.fetch_req = 0; bus.fetch_addr = 0; bus.data_req = 0; bus.data_we = 0;
    bus.data_addr = 0; bus.data_wdata = 0; bus.mem_rdata = 0; bus.mem_ack = 0;
    step(); step();
    reset = 1;
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_valids", {30'd0, bus.fetch_valid, bus.data_valid}, 0);
    chk("rst_rdata", bus.data_rdata | bus.fetch_rdata, 0);
    chk("rst_bus_error", 32'(bus.bus_error), 0);
    // reset in the middle of a data access, then a stray ack
    bus.data_req = 1; bus.data_addr = 32'h300;
    step();
    chk("t1_busy_req", 32'(bus.mem_req), 1);
    chk("t1_busy_addr", bus.mem_addr, 32'h300);
    reset = 0; bus.data_req = 0;
    step(); step();
    chk("t1_rst_req", 32'(bus.mem_req), 0);
    chk("t1_rst_addr", bus.mem_addr, 0);
    reset = 1; bus.mem_ack = 1; bus.mem_rdata = 32'hAAAA_AAAA;
    step();
    bus.mem_ack = 0;
    chk("t1_no_valid", 32'(bus.data_valid), 0);
    chk("t1_rdata", bus.data_rdata, 0);
    step();
    chk("t1_no_valid2", 32'(bus.data_valid), 0);
    // single fetch, zero-wait memory
    bus.fetch_req = 1; bus.fetch_addr = 32'h10;
    #1;
    chk("t2_flush_c0", 32'(bus.flush_e), 1);
    chk("t2_stall_data_c0", 32'(bus.stall_data), 0);
    step();
    chk("t2_mem_req", 32'(bus.mem_req), 1);
    chk("t2_mem_addr", bus.mem_addr, 32'h10);
    chk("t2_mem_we", 32'(bus.mem_we), 0);
    chk("t2_flush_c1", 32'(bus.flush_e), 1);
    bus.mem_ack = 1; bus.mem_rdata = 32'h0051_0093;
    step();
    bus.mem_ack = 0;
    chk("t2_fetch_valid", 32'(bus.fetch_valid), 1);
    chk("t2_fetch_rdata", bus.fetch_rdata, 32'h0051_0093);
    chk("t2_req_low", 32'(bus.mem_req), 0);
    chk("t2_flush_c2", 32'(bus.flush_e), 0);
    bus.fetch_req = 0;
    step();
    chk("t2_valid_pulse", 32'(bus.fetch_valid), 0);
    // simultaneous requests, data first with 3 wait states
    bus.fetch_req = 1; bus.fetch_addr = 32'h20;
    bus.data_req = 1; bus.data_we = 0; bus.data_addr = 32'h100;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("t3_stall_data", 32'(bus.stall_data), 1);
      if (c == 1) chk("t3_data_first", bus.mem_addr, 32'h100);
      if (c == 4) begin bus.mem_ack = 1; bus.mem_rdata = 32'hDEAD_BEEF; end
      step();
    end
    bus.mem_ack = 0;
    chk("t3_data_valid", 32'(bus.data_valid), 1);
    chk("t3_data_rdata", bus.data_rdata, 32'hDEAD_BEEF);
    chk("t3_stall_release", 32'(bus.stall_data), 0);
    bus.data_req = 0;
    step();
    chk("t3_idle_gap", 32'(bus.mem_req), 0);
    step();
    chk("t3_fetch_req", 32'(bus.mem_req), 1);
    chk("t3_fetch_addr", bus.mem_addr, 32'h20);
    bus.mem_ack = 1; bus.mem_rdata = 32'h13;
    step();
    bus.mem_ack = 0; bus.fetch_req = 0;
    chk("t3_fetch_valid", 32'(bus.fetch_valid), 1);
    step();
    // store leaves load data untouched
    bus.data_req = 1; bus.data_we = 1; bus.data_addr = 32'h200; bus.data_wdata = 32'h1234_5678;
    step();
    chk("t4_mem_we", 32'(bus.mem_we), 1);
    chk("t4_mem_wdata", bus.mem_wdata, 32'h1234_5678);
    chk("t4_mem_addr", bus.mem_addr, 32'h200);
    bus.mem_ack = 1; bus.mem_rdata = 32'hFFFF_FFFF;
    step();
    bus.mem_ack = 0;
    chk("t4_data_valid", 32'(bus.data_valid), 1);
    chk("t4_rdata_kept", bus.data_rdata, 32'hDEAD_BEEF);
    bus.data_req = 0; bus.data_we = 0;
    step();
    chk("t4_valid_pulse", 32'(bus.data_valid), 0);
    // data request arriving while a fetch is in flight
    bus.fetch_req = 1; bus.fetch_addr = 32'h40;
    step();
    bus.data_req = 1; bus.data_addr = 32'h500;
    #1;
    chk("t5_stall_data", 32'(bus.stall_data), 1);
    step();
    chk("t5_no_preempt", bus.mem_addr, 32'h40);
    bus.mem_ack = 1; bus.mem_rdata = 32'h33;
    step();
    bus.mem_ack = 0;
    chk("t5_fetch_valid", 32'(bus.fetch_valid), 1);
    chk("t5_stall_resp", 32'(bus.stall_data), 1);
    bus.fetch_req = 0;
    step();
    chk("t5_stall_idle", 32'(bus.stall_data), 1);
    chk("t5_idle_req", 32'(bus.mem_req), 0);
    step();
    chk("t5_dbusy_req", 32'(bus.mem_req), 1);
    chk("t5_dbusy_addr", bus.mem_addr, 32'h500);
    bus.mem_ack = 1; bus.mem_rdata = 32'h77;
    step();
    bus.mem_ack = 0;
    chk("t5_data_rdata", bus.data_rdata, 32'h77);
    bus.data_req = 0;
    step();
`ifdef ARB_TIMEOUT_EN
    bus.data_req = 1; bus.data_addr = 32'h600;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t6_busy", 32'(bus.mem_req), 1);
    end
    step();
    chk("t6_abort_valid", 32'(bus.data_valid), 1);
    chk("t6_abort_rdata", bus.data_rdata, 0);
    chk("t6_bus_error", 32'(bus.bus_error), 1);
    bus.data_req = 0;
    step(); step();
    chk("t6_sticky", 32'(bus.bus_error), 1);
`else
    bus.data_req = 1; bus.data_addr = 32'h600;
    for (int c = 0; c < 6; c++) step();
    chk("t6_waits", 32'(bus.mem_req), 1);
    chk("t6_no_error", 32'(bus.bus_error), 0);
    bus.data_req = 0;
`endif
    reset = 0;
    step();
    reset = 1;
    chk("end_rst_error", 32'(bus.bus_error), 0);
    chk("end_rst_req", 32'(bus.mem_req), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
